// File: rtl/data_sync_launcher.sv
// Source-side launcher for an enable-qualified bus crossing: registers one word
// per handshake onto a frozen bus and frames it with a HOLD-high / GAP-low enable.
module data_sync_launcher #(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [BUS_WIDTH-1:0] unsyn_bus,
  output logic                 bus_enable,
  output logic                 busy,
  output logic                 drop_err,
  output logic [CNT_WIDTH-1:0] tx_count
);

  // 8 bits covers the full 1..255 range of both phase lengths.
  localparam int PW = 8;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;
  logic                 en_q, en_d;
  logic                 drop_q, drop_d;
  logic [CNT_WIDTH-1:0] tx_q, tx_d;

  assign data_ready = (state_q == IDLE) && !RST;
  assign busy       = (state_q == HOLD) || (state_q == GAP);
  assign unsyn_bus  = bus_q;
  assign bus_enable = en_q;
  assign drop_err   = drop_q;
  assign tx_count   = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bus_d   = bus_q;
    en_d    = en_q;
    drop_d  = drop_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          bus_d   = data_in;
          en_d    = 1'b1;
          tx_d    = tx_q + CNT_WIDTH'(1);
          cnt_d   = PW'(1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == PW'(HOLD_CYCLES)) begin
          en_d    = 1'b0;
          cnt_d   = PW'(1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      GAP: begin
        if (cnt_q == PW'(GAP_CYCLES)) state_d = IDLE;
        else                          cnt_d   = cnt_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
    // A word offered while the bus is frozen is dropped; remember it until reset.
    if (data_valid && (state_q != IDLE)) drop_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bus_q   <= '0;
      en_q    <= 1'b0;
      drop_q  <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      en_q    <= en_d;
      drop_q  <= drop_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_data_sync_launcher.sv
// Bench for data_sync_launcher: three builds (default, 4-bit counter, 1/1 timing)
// driven in lockstep and checked against a timeline model plus directed vectors.
module tb_data_sync_launcher;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;

  logic [2:0] w_rdy, w_en, w_busy, w_drop;
  logic [7:0] w_bus [3];
  logic [15:0] tx0, tx2;
  logic [3:0]  tx1;

  always #5 CLK = ~CLK;

  data_sync_launcher #(.BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(3), .CNT_WIDTH(16)) dut0 (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid),
    .data_ready(w_rdy[0]), .unsyn_bus(w_bus[0]), .bus_enable(w_en[0]), .busy(w_busy[0]),
    .drop_err(w_drop[0]), .tx_count(tx0));
  data_sync_launcher #(.BUS_WIDTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(3), .CNT_WIDTH(4)) dut1 (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid),
    .data_ready(w_rdy[1]), .unsyn_bus(w_bus[1]), .bus_enable(w_en[1]), .busy(w_busy[1]),
    .drop_err(w_drop[1]), .tx_count(tx1));
  data_sync_launcher #(.BUS_WIDTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_WIDTH(16)) dut2 (
    .CLK(CLK), .RST(RST), .data_in(data_in), .data_valid(data_valid),
    .data_ready(w_rdy[2]), .unsyn_bus(w_bus[2]), .bus_enable(w_en[2]), .busy(w_busy[2]),
    .drop_err(w_drop[2]), .tx_count(tx2));

  int tests = 0, fails = 0;
  int cyc = 0, s_cyc;
  bit chk_en = 0;

  // Model: each build is described by the number of edges since its last accept.
  int H [3] = '{4, 4, 1};
  int G [3] = '{3, 3, 1};
  int TM[3] = '{65536, 16, 65536};
  int m_since[3], m_tx[3];
  logic [7:0] m_bus[3];
  logic m_drop[3];

  logic s_rdy[3], s_en[3], s_busy[3], s_drop[3];
  logic [7:0] s_bus[3];
  int s_tx[3];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0d, want %0d", name, s_cyc, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    RST = r; data_valid = v; data_in = d;
    #3;
    s_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      s_rdy[i] = w_rdy[i]; s_en[i] = w_en[i]; s_busy[i] = w_busy[i];
      s_drop[i] = w_drop[i]; s_bus[i] = w_bus[i];
    end
    s_tx[0] = int'(tx0); s_tx[1] = int'(tx1); s_tx[2] = int'(tx2);
    for (int i = 0; i < 3; i++) begin
      bit bz, ez, rz;
      bz = (m_since[i] >= 1) && (m_since[i] <= H[i] + G[i]);
      ez = (m_since[i] >= 1) && (m_since[i] <= H[i]);
      rz = !bz && !r;
      if (chk_en) begin
        tests++;
        if (s_rdy[i] !== rz || s_en[i] !== ez || s_busy[i] !== bz || s_drop[i] !== m_drop[i] ||
            s_bus[i] !== m_bus[i] || s_tx[i] != m_tx[i]) begin
          fails++;
          $display("FAIL model dut%0d cyc=%0d: rdy=%b en=%b busy=%b drop=%b bus=%h tx=%0d want rdy=%b en=%b busy=%b drop=%b bus=%h tx=%0d",
                   i, cyc, s_rdy[i], s_en[i], s_busy[i], s_drop[i], s_bus[i], s_tx[i],
                   rz, ez, bz, m_drop[i], m_bus[i], m_tx[i]);
        end
      end
      if (r) begin
        m_since[i] = 1000; m_bus[i] = '0; m_tx[i] = 0; m_drop[i] = 1'b0;
      end else if (v && !bz) begin
        m_since[i] = 1; m_bus[i] = d; m_tx[i] = (m_tx[i] + 1) % TM[i];
      end else begin
        if (v) m_drop[i] = 1'b1;
        if (m_since[i] < 1000) m_since[i]++;
      end
    end
    cyc++;
    @(posedge CLK); #1;
  endtask

  typedef struct {
    logic       rst, v;
    logic [7:0] d;
    logic       rdy, en, busy, drop;
    logic [7:0] bus;
    int         tx;
  } vec_t;
  vec_t tbl[10];

  int last, n;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0};
    tbl[1] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0};
    for (int k = 2; k <= 5; k++) tbl[k] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1};
    for (int k = 6; k <= 8; k++) tbl[k] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1};

    @(posedge CLK); #1;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk_en = 1;

    // Single word, directed vectors on the default build.
    for (int k = 0; k < 10; k++) begin
      cycle(tbl[k].rst, tbl[k].v, tbl[k].d);
      chk("vec_rdy",  int'(s_rdy[0]),  int'(tbl[k].rdy));
      chk("vec_en",   int'(s_en[0]),   int'(tbl[k].en));
      chk("vec_busy", int'(s_busy[0]), int'(tbl[k].busy));
      chk("vec_drop", int'(s_drop[0]), int'(tbl[k].drop));
      chk("vec_bus",  int'(s_bus[0]),  int'(tbl[k].bus));
      chk("vec_tx",   s_tx[0],         tbl[k].tx);
    end

    // Streaming 1,2,3 with valid held until ready.
    cycle(1, 0, 0);
    last = -1;
    for (int w = 1; w <= 3; w++) begin
      n = 0;
      do begin cycle(0, 1, 8'(w)); n++; end while (!s_rdy[0] && n < 50);
      if (!s_rdy[0]) chk("stream_timeout", 0, 1);
      if (last >= 0) chk("stream_spacing", s_cyc - last, 8);
      last = s_cyc;
    end
    for (int k = 0; k < 9; k++) cycle(0, 0, 0);
    chk("stream_tx",   s_tx[0], 3);
    chk("stream_drop", int'(s_drop[0]), 1);
    chk("stream_bus",  int'(s_bus[0]), 3);

    // Valid only during HOLD is ignored but flagged.
    cycle(1, 0, 0);
    cycle(0, 1, 8'h55);
    cycle(0, 0, 0);
    cycle(0, 1, 8'h3C);
    for (int k = 0; k < 10; k++) cycle(0, 0, 0);
    chk("hold_drop", int'(s_drop[0]), 1);
    chk("hold_bus",  int'(s_bus[0]), 8'h55);
    chk("hold_tx",   s_tx[0], 1);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("drop_clr", int'(s_drop[0]), 0);

    // Reset in the 2nd HOLD cycle aborts the transfer.
    cycle(0, 1, 8'h11);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("abort_en",  int'(s_en[0]), 0);
    chk("abort_bus", int'(s_bus[0]), 0);
    chk("abort_tx",  s_tx[0], 0);
    chk("abort_rdy", int'(s_rdy[0]), 1);
    cycle(0, 1, 8'h7E);
    cycle(0, 0, 0);
    chk("relaunch_en",  int'(s_en[0]), 1);
    chk("relaunch_bus", int'(s_bus[0]), 8'h7E);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0);

    // 4-bit transfer counter wraps after 16 words.
    cycle(1, 0, 0);
    for (int w = 0; w < 16; w++) begin
      n = 0;
      do begin cycle(0, 1, 8'(w + 8'h40)); n++; end while (!s_rdy[1] && n < 50);
      if (!s_rdy[1]) chk("wrap_timeout", 0, 1);
      if (w == 14) begin
        cycle(0, 0, 0);
        chk("wrap_pre", s_tx[1], 15);
      end
    end
    cycle(0, 0, 0);
    chk("wrap_tx",  s_tx[1], 0);
    chk("wrap_en",  int'(s_en[1]), 1);
    chk("wrap_bus", int'(s_bus[1]), 8'h4F);
    chk("wrap_tx0", s_tx[0], 16);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0);

    // Minimum timing build: one accept every 3 cycles.
    cycle(1, 0, 0);
    last = -1;
    for (int k = 0; k < 12; k++) begin
      cycle(0, 1, 8'($urandom));
      if (s_rdy[2]) begin
        if (last >= 0) chk("min_spacing", s_cyc - last, 3);
        last = s_cyc;
      end
    end

    // Random traffic against the model.
    for (int k = 0; k < 500; k++)
      cycle(($urandom % 40) == 0, 1'($urandom), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
